// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back controller.
// Holds data/address widths, source enum and the scoreboard mask helper.
package regfile_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // r0 is hardwired, so its bit never appears in any mask
    function automatic logic [NUM_REGS-1:0] rd_onehot(
        input logic [ADDR_W-1:0] rd
    );
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        m[0]  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry result holding register with a valid/ready input side.
// The slot accepts a new result in the same cycle it is being drained.
module wb_slot
    import regfile_wb_pkg::*;
#(
    parameter int RD_W = ADDR_W,
    parameter int D_W  = DATA_W
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RD_W-1:0] in_rd,
    input  logic [D_W-1:0]  in_data,
    input  logic            grant,
    output logic            full,
    output logic [RD_W-1:0] rd,
    output logic [D_W-1:0]  data
);

    logic accept;

    assign in_ready = !full || grant;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            rd   <= '0;
            data <= '0;
        end else if (accept) begin
            full <= 1'b1;
            rd   <= in_rd;
            data <= in_data;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: ALU/load slots, round-robin arbiter,
// busy scoreboard and RAW hazard flag. Optional bypass via WB_BYPASS_EN.
module regfile_wb_ctrl
    import regfile_wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_rd,
    input  logic [ADDR_W-1:0]   chk_rs,
    input  logic [ADDR_W-1:0]   chk_rt,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_mask,
`ifdef WB_BYPASS_EN
    output logic                fwd_a_sel,
    output logic                fwd_b_sel,
    output logic [DATA_W-1:0]   fwd_data,
`endif
    output logic                wb_we,
    output logic [ADDR_W-1:0]   wb_rd,
    output logic [DATA_W-1:0]   wb_data
);

    logic              alu_full;
    logic [ADDR_W-1:0] alu_rd_q;
    logic [DATA_W-1:0] alu_data_q;
    logic              mem_full;
    logic [ADDR_W-1:0] mem_rd_q;
    logic [DATA_W-1:0] mem_data_q;

    logic              grant_alu;
    logic              grant_mem;
    logic              grant_any;
    logic [ADDR_W-1:0] g_rd;
    logic [DATA_W-1:0] g_data;
    src_e              last_grant;

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    logic src_busy;
    logic wb_hit_a;
    logic wb_hit_b;

    wb_slot #(.RD_W(ADDR_W), .D_W(DATA_W)) u_alu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_rd    (alu_rd),
        .in_data  (alu_data),
        .grant    (grant_alu),
        .full     (alu_full),
        .rd       (alu_rd_q),
        .data     (alu_data_q)
    );

    wb_slot #(.RD_W(ADDR_W), .D_W(DATA_W)) u_mem_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (mem_valid),
        .in_ready (mem_ready),
        .in_rd    (mem_rd),
        .in_data  (mem_data),
        .grant    (grant_mem),
        .full     (mem_full),
        .rd       (mem_rd_q),
        .data     (mem_data_q)
    );

    // On contention the source that did not win last time goes first
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        priority case (1'b1)
            alu_full && mem_full: begin
                grant_alu = (last_grant == SRC_MEM);
                grant_mem = (last_grant == SRC_ALU);
            end
            alu_full: grant_alu = 1'b1;
            mem_full: grant_mem = 1'b1;
            default: ;
        endcase
    end

    assign grant_any = grant_alu || grant_mem;
    assign g_rd      = grant_alu ? alu_rd_q   : mem_rd_q;
    assign g_data    = grant_alu ? alu_data_q : mem_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_MEM;
        end else if (grant_any) begin
            last_grant <= grant_alu ? SRC_ALU : SRC_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= grant_any && (g_rd != '0);
            if (grant_any) begin
                wb_rd   <= g_rd;
                wb_data <= g_data;
            end
        end
    end

    assign set_mask = iss_valid ? rd_onehot(iss_rd) : '0;
    assign clr_mask = grant_any ? rd_onehot(g_rd)   : '0;

    // A same-edge issue to the retiring register keeps the bit pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= (busy_mask & ~clr_mask) | set_mask;
        end
    end

    assign src_busy = busy_mask[chk_rs] || busy_mask[chk_rt];
    assign wb_hit_a = wb_we && (wb_rd == chk_rs) && (chk_rs != '0);
    assign wb_hit_b = wb_we && (wb_rd == chk_rt) && (chk_rt != '0);

`ifdef WB_BYPASS_EN
    assign fwd_a_sel = wb_hit_a;
    assign fwd_b_sel = wb_hit_b;
    assign fwd_data  = wb_data;
    assign hazard    = src_busy;
`else
    assign hazard    = src_busy || wb_hit_a || wb_hit_b;
`endif

endmodule
